// File: rtl/dot_product_accumulator_if.sv
// Product-stream input and dot-product result handshake bundle.
// Carries both valid/ready channels of the accumulator.
interface dot_product_accumulator_if #(
  parameter int DATA_W = 64,
  parameter int LEN    = 8,
  parameter int CNT_W  = $clog2(LEN+1),
  parameter int ACC_W  = DATA_W + $clog2(LEN)
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/dot_product_accumulator.sv
// Sums up to LEN unsigned product terms into one dot-product result.
// Terms arrive on a valid/ready stream; results leave on another.
module dot_product_accumulator #(
  parameter int DATA_W = 64,
  parameter int LEN    = 8,
  parameter int CNT_W  = $clog2(LEN+1),
  parameter int ACC_W  = DATA_W + $clog2(LEN)
) (
  input  logic clk,
  input  logic rst,
  dot_product_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    INIT,
    ACC,
    SEND
  } state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rdy_q, rdy_d;
  logic              vld_q, vld_d;
  logic [ACC_W-1:0]  dat_q, dat_d;
  logic [CNT_W-1:0]  ocnt_q, ocnt_d;
  logic [ACC_W-1:0]  sum;
  logic              fin;

  assign sum = acc_q + ACC_W'(bus.in_data);
  // A LEN-th term with in_last set is still a single termination.
  assign fin = bus.in_last || (cnt_q == CNT_W'(LEN-1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    rdy_d   = rdy_q;
    vld_d   = vld_q;
    dat_d   = dat_q;
    ocnt_d  = ocnt_q;
    unique case (state_q)
      INIT: begin
        rdy_d   = 1'b1;
        state_d = ACC;
      end
      ACC: begin
        if (bus.in_valid && rdy_q) begin
          if (fin) begin
            dat_d   = sum;
            ocnt_d  = cnt_q + CNT_W'(1);
            vld_d   = 1'b1;
            rdy_d   = 1'b0;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = SEND;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      SEND: begin
        if (vld_q && bus.out_ready) begin
          vld_d   = 1'b0;
          rdy_d   = 1'b1;
          state_d = ACC;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
      acc_q   <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
      ocnt_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      ocnt_q  <= ocnt_d;
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = vld_q;
  assign bus.out_data  = dat_q;
  assign bus.out_count = ocnt_q;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench for dot_product_accumulator, LEN=4, DATA_W=8.
// Inputs change and outputs are sampled on the falling edge.
module tb_dot_product_accumulator;

  localparam int DATA_W = 8;
  localparam int LEN    = 4;
  localparam int CNT_W  = $clog2(LEN+1);
  localparam int ACC_W  = DATA_W + $clog2(LEN);

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  dot_product_accumulator_if #(
    .DATA_W(DATA_W), .LEN(LEN)
  ) bus ();

  dot_product_accumulator #(
    .DATA_W(DATA_W), .LEN(LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input int d, input bit l);
    int i;
    bus.in_valid = 1'b1;
    bus.in_data  = DATA_W'(d);
    bus.in_last  = l;
    for (i = 0; i < 20; i++) begin
      if (bus.in_ready === 1'b1) break;
      @(negedge clk);
    end
    if (bus.in_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL send_timeout in_ready=%0b required 1", bus.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    #12;
    tests++;
    if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
      fails++;
      $display("FAIL reset_flags got %b required 00",
               {bus.in_ready, bus.out_valid});
    end
    tests++;
    if (bus.out_data !== '0 || bus.out_count !== '0) begin
      fails++;
      $display("FAIL reset_data got %0d/%0d required 0/0",
               bus.out_data, bus.out_count);
    end
    @(negedge clk);
    rst = 1'b1;
    tests++;
    if (bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL release_early in_ready=%0b required 0", bus.in_ready);
    end
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL release_one_edge in_ready=%0b required 1", bus.in_ready);
    end
  endtask

  task automatic test_full_vector();
    bus.out_ready = 1'b1;
    send(3, 0);
    send(5, 0);
    send(7, 0);
    send(9, 0);
    idle();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL full_flags vld/rdy=%b%b required 10",
               bus.out_valid, bus.in_ready);
    end
    tests++;
    if (bus.out_data !== ACC_W'(24) || bus.out_count !== CNT_W'(4)) begin
      fails++;
      $display("FAIL full_sum got %0d/%0d required 24/4",
               bus.out_data, bus.out_count);
    end
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL full_one_cycle vld/rdy=%b%b required 01",
               bus.out_valid, bus.in_ready);
    end
    tests++;
    if (bus.out_data !== ACC_W'(24)) begin
      fails++;
      $display("FAIL full_hold got %0d required 24", bus.out_data);
    end
  endtask

  task automatic test_early_last();
    bus.out_ready = 1'b1;
    send(10, 0);
    send(20, 1);
    idle();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== ACC_W'(30) ||
        bus.out_count !== CNT_W'(2)) begin
      fails++;
      $display("FAIL early_sum vld=%b got %0d/%0d required 30/2",
               bus.out_valid, bus.out_data, bus.out_count);
    end
    send(1, 0);
    send(1, 0);
    send(1, 0);
    send(1, 1);
    idle();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== ACC_W'(4) ||
        bus.out_count !== CNT_W'(4)) begin
      fails++;
      $display("FAIL no_carry vld=%b got %0d/%0d required 4/4",
               bus.out_valid, bus.out_data, bus.out_count);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int bad;
    bus.out_ready = 1'b0;
    send(6, 0);
    send(7, 1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.in_data  = 8'd99;
      bus.in_last  = 1'b0;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.out_data !== ACC_W'(13) || bus.out_count !== CNT_W'(2))
        bad++;
      @(negedge clk);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL bp_hold bad_cycles=%0d required 0", bad);
    end
    idle();
    bus.out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release vld/rdy=%b%b required 01",
               bus.out_valid, bus.in_ready);
    end
    send(2, 1);
    idle();
    tests++;
    if (bus.out_data !== ACC_W'(2) || bus.out_count !== CNT_W'(1)) begin
      fails++;
      $display("FAIL single_term got %0d/%0d required 2/1",
               bus.out_data, bus.out_count);
    end
    @(negedge clk);
  endtask

  task automatic test_width_limit();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(255, 0);
    idle();
    tests++;
    if (bus.out_data !== ACC_W'(1020) || bus.out_count !== CNT_W'(4)) begin
      fails++;
      $display("FAIL width got %0d/%0d required 1020/4",
               bus.out_data, bus.out_count);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    send(100, 0);
    send(50, 0);
    idle();
    #2 rst = 1'b0;
    #1;
    tests++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.out_data !== '0) begin
      fails++;
      $display("FAIL mid_reset rdy/vld=%b%b data=%0d required 00/0",
               bus.in_ready, bus.out_valid, bus.out_data);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(2, 0);
    send(3, 0);
    send(4, 0);
    send(5, 0);
    idle();
    tests++;
    if (bus.out_data !== ACC_W'(14) || bus.out_count !== CNT_W'(4)) begin
      fails++;
      $display("FAIL after_reset got %0d/%0d required 14/4",
               bus.out_data, bus.out_count);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(9, 1);
    idle();
    #2 rst = 1'b0;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.out_count !== '0) begin
      fails++;
      $display("FAIL send_reset vld=%b cnt=%0d required 0/0",
               bus.out_valid, bus.out_count);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_full_vector();
    test_early_last();
    test_backpressure();
    test_width_limit();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
